mux16_rr_arbiter: RTL
=====================

# mux16_rr_arbiter

Round-robin arbiter and sequencer for the 16-bit 8:1 source mux in the RiscV datapath. It shares the mux output among eight requesters, drives the mux select, and issues one-hot grants. It moves data beats downstream over a valid/ready handshake and bounds each requester's tenure to a configurable burst length. The mux data path itself stays outside this block; this block only produces `sel` and the handshake and grant control.

## Interface
- `BURST_MAX`, default 4: maximum beats per grant. Legal range is 1..16.
- `clk`  input  1: rising-edge clock.
- `rst_n`  input  1: asynchronous reset, active-low.
- `req`  input  8: request per source. Bit i corresponds to mux input A_i. The requester holds the bit while it has data.
- `last`  input  8: per source, marks the current beat as the final beat of the packet.
- `out_ready`  input  1: downstream accepts the beat this cycle.
- `sel`  output  3: mux select. Connect it directly to the mux `s` input.
- `gnt`  output  8: one-hot grant. It is all-zero when no source is granted.
- `out_valid`  output  1: the mux output holds a valid beat.
- `busy`  output  1: high while in state GRANT.

## Operation
- The FSM has two states, IDLE and GRANT.
- Internal registers:
  - `ptr[2:0]`: index of the last granted source.
  - `beat_cnt`: width $clog2(BURST_MAX)+1.
- IDLE:
  - If `req` != 0 at a clock edge, pick the first set bit scanning ptr+1, ptr+2, …, ptr+8, modulo 8 (wrap 7→0).
  - At that edge, load `sel` with the index, set `gnt` to the one-hot of the index, clear `beat_cnt` to 0, and go to GRANT.
  - If `req` = 0, stay in IDLE. `gnt` = 0 and `sel` holds its previous value.
- GRANT:
  - `out_valid` = `req[sel]`. This is combinational from registered `sel`/state and live `req`. It is 0 in IDLE.
  - A beat is the condition `out_valid && out_ready` at a clock edge. Each beat increments `beat_cnt`.
  - Release occurs at the edge where any of the following holds:
    - (a) a beat occurs with `last[sel]` = 1;
    - (b) a beat occurs with `beat_cnt` == BURST_MAX-1;
    - (c) `req[sel]` = 0, meaning the requester withdrew. No beat occurs in this case.
  - On release: set `ptr` to `sel`, clear `gnt` to 0, and go to IDLE. `sel` holds.
- Every release is followed by exactly one IDLE cycle. Back-to-back grants therefore have a 1-cycle bubble.
- Burst-limit release (b) does not drop the requester's packet. The requester keeps `req` high and re-arbitrates after the other requesters.
- Priority rules:
  - Only `req` bits are arbitrated. `last` is ignored outside GRANT, and `last` bits of ungranted sources are ignored.
  - While in GRANT, changes on other `req` bits have no effect.
- Reset (`rst_n` low, asynchronous, at any time including mid-burst) sets:
  - state = IDLE, `gnt` = 0, `sel` = 0, `ptr` = 7 (so source 0 wins first), `beat_cnt` = 0;
  - hence `out_valid` = 0 and `busy` = 0.
  - An in-flight beat is discarded.
- Reset release is synchronised externally. The first arbitration may occur on the first edge after `rst_n` rises.

## Timing
- Request to grant latency:
  - `req` is sampled high at edge k in IDLE.
  - `gnt`, `sel`, `busy` and `out_valid` are high after edge k.
  - The first beat can complete at edge k+1.
- Throughput:
  - With `out_ready` held high, a BURST_MAX burst takes BURST_MAX cycles plus 1 IDLE cycle.
  - Peak utilisation is BURST_MAX/(BURST_MAX+1).
- Backpressure:
  - When `out_ready` = 0, `sel`, `gnt` and `beat_cnt` are stable. The hold has no timeout.
  - `out_valid` must not depend on `out_ready`.
- Output timing:
  - `gnt`, `sel` and `busy` are registered.
  - `out_valid` is one AND gate from `req`.

## Test plan
- Reset: assert `rst_n` = 0 with `req` = 8'hFF. Required: `gnt` = 0, `sel` = 0, `out_valid` = 0, `busy` = 0. Release reset. Required: after the first edge, `gnt` = 8'h01 and `sel` = 0.
- Fairness:
  - Stimulus: `req` = 8'hFF continuously, `last` = 8'hFF, `out_ready` = 1.
  - Required: grant order 0,1,2,…,7,0. Each grant lasts 1 cycle and is followed by 1 IDLE cycle, giving 16 cycles per full rotation.
- Burst limit:
  - Stimulus: BURST_MAX = 4, `req` = 8'h09, `last` = 0, `out_ready` = 1.
  - Required: source 0 gets 4 beats, then IDLE, then source 3 gets 4 beats, then source 0 again.
- Backpressure:
  - Stimulus: source 5 granted, `out_ready` = 0 for 6 cycles, then 1 with `last[5]` = 1.
  - Required: `sel` = 5 and `out_valid` = 1 are held for 6 cycles. There is exactly one beat, then release, and `ptr` = 5. A subsequent `req` = 8'hFF grants source 6.
- Withdrawal:
  - Stimulus: source 2 granted, `req[2]` drops after 1 beat.
  - Required: `out_valid` falls the same cycle. Release occurs at the next edge with no extra beat counted, and the next grant goes to the first source after 2.
- Reset mid-burst:
  - Stimulus: `rst_n` pulses low asynchronously during the 2nd beat of source 4, mid-cycle.
  - Required: `gnt` = 0 and `out_valid` = 0 immediately, without waiting for a clock edge. After release, source 0 has priority (`ptr` = 7).

Source files
------------

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter for the 8:1 16-bit source mux: drives the mux select,
// one-hot grants and a valid/ready beat handshake with a per-grant burst limit.
module mux16_rr_arbiter #(
   parameter int BURST_MAX = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic [7:0] last,
   input  logic       out_ready,
   output logic [2:0] sel,
   output logic [7:0] gnt,
   output logic       out_valid,
   output logic       busy
);

   localparam int CW = $clog2(BURST_MAX) + 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_MAX - 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t        state, state_nxt;
   logic [2:0]    ptr, ptr_nxt, sel_nxt, pick, cand;
   logic [7:0]    gnt_nxt;
   logic [CW-1:0] beat_cnt, beat_cnt_nxt;
   logic          beat, release_now;

   // Scan from the farthest offset down so the nearest requester after ptr wins.
   always_comb begin
      pick = ptr;
      cand = ptr;
      for (int i = 8; i >= 1; i--) begin
         cand = ptr + 3'(i);
         if (req[cand]) pick = cand;
      end
   end

   assign busy        = (state == GRANT);
   assign out_valid   = busy && req[sel];
   assign beat        = out_valid && out_ready;
   assign release_now = !req[sel] || (beat && (last[sel] || beat_cnt == LAST_BEAT));

   always_comb begin
      // NOTE: every output of this block gets a hold default first, so no path can infer a latch.
      state_nxt    = state;
      ptr_nxt      = ptr;
      sel_nxt      = sel;
      gnt_nxt      = gnt;
      beat_cnt_nxt = beat_cnt;
      case (state)
         IDLE: begin
            if (req != 8'h00) begin
               state_nxt    = GRANT;
               sel_nxt      = pick;
               gnt_nxt      = 8'h01 << pick;
               beat_cnt_nxt = '0;
            end
         end
         GRANT: begin
            if (beat) beat_cnt_nxt = beat_cnt + CW'(1);
            if (release_now) begin
               state_nxt = IDLE;
               ptr_nxt   = sel;
               gnt_nxt   = 8'h00;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= 3'd7;
         sel      <= 3'd0;
         gnt      <= 8'h00;
         beat_cnt <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         sel      <= sel_nxt;
         gnt      <= gnt_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

endmodule
